// File: rtl/decision_scheduler.sv
// decision_scheduler: symbol-timing strobe generator with a hard-decision
// output buffer. A phase counter divides the sample clock by SPS, with
// one-sample advance/retard adjustments at most once per symbol. After
// ACQ_SYMBOLS discarded strobes the block tracks, slicing the sign of the
// I/Q matched-filter outputs into 2-bit decisions for a ready/valid consumer.
// Build option: define DECISION_FIFO_EN for a 4-entry FIFO instead of a
// single holding register.
module decision_scheduler #(
  parameter int SPS         = 4,
  parameter int ACQ_SYMBOLS = 8
) (
  input  logic        clk_fs,
  input  logic        rst_n,
  input  logic        enable,
  input  logic [3:0]  phase_init,
  input  logic        adv_req,
  input  logic        ret_req,
  input  logic [35:0] filter_in_I,
  input  logic [35:0] filter_in_Q,
  input  logic        out_ready,
  output logic        sample_strobe,
  output logic [1:0]  bit_out_I,
  output logic [1:0]  bit_out_Q,
  output logic        out_valid,
  output logic [1:0]  state,
  output logic        overflow,
  output logic [15:0] sym_count
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_ACQ   = 2'b01,
    S_TRACK = 2'b10
  } state_t;

  localparam logic [3:0] CNT_LAST    = 4'(SPS - 1);
  localparam logic [3:0] CNT_ADV_LIM = 4'(SPS - 2);
  localparam logic [4:0] SPS_V       = 5'(SPS);
  localparam logic [7:0] ACQ_LAST    = 8'(ACQ_SYMBOLS - 1);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        adj_q, adj_d;
  logic [7:0]  acq_q, acq_d;
  logic        ovf_q, ovf_d;
  logic [15:0] sym_q;

  logic        strobe;
  logic        push, pop, flush, load, val;
  logic [1:0]  dec_i, dec_q;
  // Only the sign bits carry the decision; the magnitude bits are ignored.
  logic        unused_mag;

  assign unused_mag = ^{filter_in_I[34:0], filter_in_Q[34:0]};

  assign strobe = (cnt_q == CNT_LAST) && ((state_q == S_ACQ) || (state_q == S_TRACK));
  assign dec_i  = filter_in_I[35] ? 2'b11 : 2'b01;
  assign dec_q  = filter_in_Q[35] ? 2'b11 : 2'b01;
  assign push   = strobe && (state_q == S_TRACK) && enable;
  assign flush  = (state_d == S_IDLE);
  assign pop    = val && out_ready;

  // Next state, phase counter, per-symbol adjust lock and acquire count.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    adj_d   = adj_q;
    acq_d   = acq_q;
    if (!enable) begin
      state_d = S_IDLE;
      cnt_d   = 4'd0;
      adj_d   = 1'b0;
      acq_d   = 8'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          state_d = S_ACQ;
          cnt_d   = ({1'b0, phase_init} < SPS_V) ? phase_init : 4'd0;
          adj_d   = 1'b0;
          acq_d   = 8'd0;
        end
        S_ACQ, S_TRACK: begin
          if (strobe) begin
            // Wrap; a fresh symbol re-arms the adjustment.
            cnt_d = 4'd0;
            adj_d = 1'b0;
            if (state_q == S_ACQ) begin
              if (acq_q == ACQ_LAST) state_d = S_TRACK;
              else                   acq_d   = acq_q + 8'd1;
            end
          end else if (adv_req && !ret_req && !adj_q && (cnt_q < CNT_ADV_LIM)) begin
            // Skip a sample, but never past the decision instant.
            cnt_d = cnt_q + 4'd2;
            adj_d = 1'b1;
          end else if (ret_req && !adv_req && !adj_q) begin
            // Hold for one sample; the strobe case above keeps it unrepeated.
            adj_d = 1'b1;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
        default: begin
          state_d = S_IDLE;
          cnt_d   = 4'd0;
        end
      endcase
    end
  end

  // Control registers.
  always_ff @(posedge clk_fs or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      adj_q   <= 1'b0;
      acq_q   <= 8'd0;
      ovf_q   <= 1'b0;
      sym_q   <= 16'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      adj_q   <= adj_d;
      acq_q   <= acq_d;
      ovf_q   <= ovf_d;
      if (pop) sym_q <= sym_q + 16'd1;
    end
  end

`ifdef DECISION_FIFO_EN
  logic [1:0] mem_i [4];
  logic [1:0] mem_q [4];
  logic [1:0] rd_q, rd_d, wr_q, wr_d;
  logic [2:0] fill_q, fill_d;

  assign val  = (fill_q != 3'd0);
  // A pop in the same cycle frees the slot the push needs.
  assign load = push && ((fill_q != 3'd4) || pop);

  // FIFO pointers, occupancy and the sticky drop flag.
  always_comb begin
    rd_d   = rd_q;
    wr_d   = wr_q;
    fill_d = fill_q;
    ovf_d  = ovf_q;
    if (flush) begin
      rd_d   = 2'd0;
      wr_d   = 2'd0;
      fill_d = 3'd0;
      ovf_d  = 1'b0;
    end else begin
      if (push && !load) ovf_d = 1'b1;
      rd_d   = rd_q + {1'b0, pop};
      wr_d   = wr_q + {1'b0, load};
      fill_d = fill_q + {2'b00, load} - {2'b00, pop};
    end
  end

  // FIFO control registers.
  always_ff @(posedge clk_fs or negedge rst_n) begin
    if (!rst_n) begin
      rd_q   <= 2'd0;
      wr_q   <= 2'd0;
      fill_q <= 3'd0;
    end else begin
      rd_q   <= rd_d;
      wr_q   <= wr_d;
      fill_q <= fill_d;
    end
  end

  // FIFO storage; contents are only visible while valid.
  always_ff @(posedge clk_fs) begin
    if (load) begin
      mem_i[wr_q] <= dec_i;
      mem_q[wr_q] <= dec_q;
    end
  end

  assign bit_out_I = val ? mem_i[rd_q] : 2'b00;
  assign bit_out_Q = val ? mem_q[rd_q] : 2'b00;
`else
  logic       val_q, val_d;
  logic [1:0] bi_q, bq_q;

  assign val  = val_q;
  // A pop in the same cycle frees the register for the new decision.
  assign load = push && (!val_q || pop);

  // Holding-register occupancy and the sticky drop flag.
  always_comb begin
    val_d = val_q;
    ovf_d = ovf_q;
    if (flush) begin
      val_d = 1'b0;
      ovf_d = 1'b0;
    end else if (push) begin
      if (load) val_d = 1'b1;
      else      ovf_d = 1'b1;
    end else if (pop) begin
      val_d = 1'b0;
    end
  end

  // Holding-register valid flag.
  always_ff @(posedge clk_fs or negedge rst_n) begin
    if (!rst_n) val_q <= 1'b0;
    else        val_q <= val_d;
  end

  // Decision data; only visible while valid.
  always_ff @(posedge clk_fs) begin
    if (load) begin
      bi_q <= dec_i;
      bq_q <= dec_q;
    end
  end

  assign bit_out_I = val_q ? bi_q : 2'b00;
  assign bit_out_Q = val_q ? bq_q : 2'b00;
`endif

  assign sample_strobe = strobe;
  assign out_valid     = val;
  assign state         = state_q;
  assign overflow      = ovf_q;
  assign sym_count     = sym_q;

endmodule

// File: tb/tb_decision_scheduler.sv
// Directed bench for decision_scheduler (SPS=4, ACQ_SYMBOLS=8).
module tb_decision_scheduler;

  logic        clk_fs = 1'b0;
  logic        rst_n, enable, adv_req, ret_req, out_ready;
  logic [3:0]  phase_init;
  logic [35:0] filter_in_I, filter_in_Q;
  logic        sample_strobe, out_valid, overflow;
  logic [1:0]  bit_out_I, bit_out_Q, state;
  logic [15:0] sym_count;

  int n_cmp = 0;
  int n_err = 0;
  int n_trk = 0;
  int g;

`ifdef DECISION_FIFO_EN
  localparam int DEPTH = 4;
`else
  localparam int DEPTH = 1;
`endif

  decision_scheduler #(.SPS(4), .ACQ_SYMBOLS(8)) dut (
    .clk_fs(clk_fs), .rst_n(rst_n), .enable(enable), .phase_init(phase_init),
    .adv_req(adv_req), .ret_req(ret_req),
    .filter_in_I(filter_in_I), .filter_in_Q(filter_in_Q), .out_ready(out_ready),
    .sample_strobe(sample_strobe), .bit_out_I(bit_out_I), .bit_out_Q(bit_out_Q),
    .out_valid(out_valid), .state(state), .overflow(overflow), .sym_count(sym_count)
  );

  always #50 clk_fs = ~clk_fs;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_fs);
    #1;
  endtask

  // Advance to the next strobe cycle; gap = cycles moved.
  task automatic next_strobe(output int gap);
    gap = 0;
    do begin
      tick();
      gap++;
    end while (!sample_strobe && gap < 64);
    if (!sample_strobe) check("strobe_timeout", 32'(sample_strobe), 32'd1);
  endtask

  function automatic logic [1:0] exp_i(input int k);
    return k[0] ? 2'b11 : 2'b01;
  endfunction

  function automatic logic [1:0] exp_q(input int k);
    return k[1] ? 2'b11 : 2'b01;
  endfunction

  task automatic set_pat(input int k);
    filter_in_I = k[0] ? 36'h800000000 : 36'h000000005;
    filter_in_Q = k[1] ? 36'hF00000123 : 36'h7FFFFFFFF;
  endtask

  task automatic acquire(input int first_gap);
    int gl;
    for (int i = 1; i <= 8; i++) begin
      next_strobe(gl);
      check("acq_gap", 32'(gl), 32'(i == 1 ? first_gap : 4));
      check("acq_state", 32'(state), 32'd1);
      check("acq_valid", 32'(out_valid), 32'd0);
    end
    tick();
    check("track_entry", 32'(state), 32'd2);
    check("track_valid", 32'(out_valid), 32'd0);
  endtask

  initial begin
    rst_n = 1'b1; enable = 1'b0; adv_req = 1'b0; ret_req = 1'b0; out_ready = 1'b1;
    phase_init = 4'd0; filter_in_I = 36'd0; filter_in_Q = 36'd0;
    #5 rst_n = 1'b0;
    #1;
    check("rst_state", 32'(state), 32'd0);
    check("rst_strobe", 32'(sample_strobe), 32'd0);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_ovf", 32'(overflow), 32'd0);
    check("rst_sym", 32'(sym_count), 32'd0);
    check("rst_bits", 32'({bit_out_I, bit_out_Q}), 32'd0);
    repeat (2) tick();
    rst_n = 1'b1;
    enable = 1'b1;
    tick();
    check("idle_to_acq", 32'(state), 32'd1);
    acquire(3);

    // First decisions in TRACK, consumer always ready.
    filter_in_I = 36'h800000000; filter_in_Q = 36'h000000001;
    next_strobe(g); n_trk++;
    tick();
    check("dec1_I", 32'(bit_out_I), 32'd3);
    check("dec1_Q", 32'(bit_out_Q), 32'd1);
    check("dec1_valid", 32'(out_valid), 32'd1);
    check("dec1_sym_pre", 32'(sym_count), 32'd0);
    tick();
    check("dec1_sym_post", 32'(sym_count), 32'd1);
    check("dec1_popped", 32'(out_valid), 32'd0);
    filter_in_I = 36'h7FFFFFFFF; filter_in_Q = 36'hFFFFFFFFF;
    next_strobe(g); n_trk++;
    tick();
    check("dec2_I", 32'(bit_out_I), 32'd1);
    check("dec2_Q", 32'(bit_out_Q), 32'd3);
    tick();
    check("dec2_sym", 32'(sym_count), 32'd2);

    // Timing adjustments, each measured strobe to strobe.
    next_strobe(g); n_trk++;
    tick(); adv_req = 1'b1; tick(); adv_req = 1'b0;
    next_strobe(g); n_trk++;
    check("adv_gap", 32'(2 + g), 32'd3);
    tick(); tick(); ret_req = 1'b1; tick(); ret_req = 1'b0;
    next_strobe(g); n_trk++;
    check("ret_gap", 32'(3 + g), 32'd5);
    tick(); adv_req = 1'b1; ret_req = 1'b1; tick(); adv_req = 1'b0; ret_req = 1'b0;
    next_strobe(g); n_trk++;
    check("both_gap", 32'(2 + g), 32'd4);
    tick(); ret_req = 1'b1; tick(); tick(); ret_req = 1'b0;
    next_strobe(g); n_trk++;
    check("ret_twice_gap", 32'(3 + g), 32'd5);
    tick(); tick(); tick(); adv_req = 1'b1; tick(); adv_req = 1'b0;
    check("adv_late_strobe", 32'(sample_strobe), 32'd1);
    n_trk++;

    // Drop enable while a decision is pending.
    tick();
    check("pend_valid", 32'(out_valid), 32'd1);
    out_ready = 1'b0; enable = 1'b0;
    tick();
    check("dis_state", 32'(state), 32'd0);
    check("dis_valid", 32'(out_valid), 32'd0);
    check("dis_sym", 32'(sym_count), 32'(n_trk - 1));
    for (int i = 0; i < 5; i++) begin
      tick();
      check("idle_strobe", 32'(sample_strobe), 32'd0);
    end

    // Re-acquire from phase 2, then back-pressure for six symbols.
    phase_init = 4'd2; enable = 1'b1;
    tick();
    check("reacq_state", 32'(state), 32'd1);
    acquire(1);
    for (int k = 1; k <= 6; k++) begin
      set_pat(k);
      next_strobe(g);
      tick();
      check("ovf_flag", 32'(overflow), 32'(k > DEPTH ? 1 : 0));
      check("hold_valid", 32'(out_valid), 32'd1);
      check("hold_I", 32'(bit_out_I), 32'(exp_i(1)));
      check("hold_Q", 32'(bit_out_Q), 32'(exp_q(1)));
    end
    out_ready = 1'b1;
    for (int j = 1; j <= DEPTH; j++) begin
      check("drain_valid", 32'(out_valid), 32'd1);
      check("drain_I", 32'(bit_out_I), 32'(exp_i(j)));
      check("drain_Q", 32'(bit_out_Q), 32'(exp_q(j)));
      tick();
    end

    // Asynchronous reset with a pending decision and overflow set.
    out_ready = 1'b0;
    next_strobe(g);
    tick();
    check("pre_rst_valid", 32'(out_valid), 32'd1);
    check("pre_rst_ovf", 32'(overflow), 32'd1);
    #20 rst_n = 1'b0;
    #1;
    check("arst_state", 32'(state), 32'd0);
    check("arst_strobe", 32'(sample_strobe), 32'd0);
    check("arst_valid", 32'(out_valid), 32'd0);
    check("arst_bits", 32'({bit_out_I, bit_out_Q}), 32'd0);
    check("arst_ovf", 32'(overflow), 32'd0);
    check("arst_sym", 32'(sym_count), 32'd0);
    #10 rst_n = 1'b1;
    phase_init = 4'd9; out_ready = 1'b1;
    tick();
    check("resume_state", 32'(state), 32'd1);
    next_strobe(g);
    check("init_clamp_gap", 32'(g), 32'd3);
    check("resume_valid", 32'(out_valid), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
